// File: rtl/spcpu_mem_arbiter.sv
// spcpu_mem_arbiter
// Shares the single 16-bit memory port between the instruction-fetch
// sequencer (IF) and the load/store unit (LS). One access at a time; the
// memory-side lines are registered and held for MEM_LAT cycles.
//
// Optional feature: define SPCPU_MEM_ARB_RR_EN for round-robin arbitration
// on simultaneous requests. Default build is fixed priority, LS over IF.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; mem_we low; any pending request is granted
// BUSY  | memory lines driven from latched request; counter runs to zero
module spcpu_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_sz,
  output logic                  if_gnt,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,

  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic                  ls_sz,
  input  logic                  ls_we,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_done,
  output logic [DATA_WIDTH-1:0] ls_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_acc_sz,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Access-size encoding shared with the core (pkg_cpu).
  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;

  // Counter is loaded with MEM_LAT-1 so the last BUSY cycle sees zero.
  localparam logic [3:0] LP_CNT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_owner_ls;

  logic                  r_if_gnt;
  logic                  r_if_done;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic                  r_ls_gnt;
  logic                  r_ls_done;
  logic [DATA_WIDTH-1:0] r_ls_rdata;

  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic                  r_mem_sz;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic                  w_any_req;
  logic                  w_pick_ls;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_any_req = if_req | ls_req;

`ifdef SPCPU_MEM_ARB_RR_EN
  // 1 = LS was granted last; reset value means IF-last, so LS wins the first tie.
  logic r_last_ls;

  // On a tie the requester not granted last wins; a lone requester always wins.
  assign w_pick_ls = ls_req & (~if_req | ~r_last_ls);

  // Pointer follows every grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_ls <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_last_ls <= w_pick_ls;
    end
  end
`else
  // Fixed priority: LS over IF.
  assign w_pick_ls = ls_req;
`endif

  // Byte reads are zero-extended from the low lane of the memory bus.
  assign w_rd_data = (r_mem_sz == cpu_data_acc_sz_8)
                     ? {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]}
                     : mem_rdata;

  // Arbitration FSM: grant, hold memory lines for MEM_LAT cycles, complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_owner_ls  <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_if_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_gnt    <= 1'b0;
      r_ls_done   <= 1'b0;
      r_ls_rdata  <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_sz    <= cpu_data_acc_sz_16;
      r_mem_wdata <= '0;
    end else begin
      r_if_gnt  <= 1'b0;
      r_ls_gnt  <= 1'b0;
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mem_we <= 1'b0;
          if (w_any_req) begin
            r_state    <= ST_BUSY;
            r_cnt      <= LP_CNT_LOAD;
            r_owner_ls <= w_pick_ls;
            if (w_pick_ls) begin
              r_mem_addr  <= ls_addr;
              r_mem_sz    <= ls_sz;
              r_mem_we    <= ls_we;
              r_mem_wdata <= ls_wdata;
              r_ls_gnt    <= 1'b1;
            end else begin
              // IF only reads; mem_wdata keeps its previous value.
              r_mem_addr <= if_addr;
              r_mem_sz   <= if_sz;
              r_mem_we   <= 1'b0;
              r_if_gnt   <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state  <= ST_IDLE;
            r_mem_we <= 1'b0;
            if (r_owner_ls) begin
              r_ls_done <= 1'b1;
              if (!r_mem_we) begin
                r_ls_rdata <= w_rd_data;
              end
            end else begin
              r_if_done  <= 1'b1;
              r_if_rdata <= w_rd_data;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_gnt     = r_if_gnt;
  assign if_done    = r_if_done;
  assign if_rdata   = r_if_rdata;
  assign ls_gnt     = r_ls_gnt;
  assign ls_done    = r_ls_done;
  assign ls_rdata   = r_ls_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_acc_sz = r_mem_sz;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_spcpu_mem_arbiter.sv
// Bench for spcpu_mem_arbiter: one instance at MEM_LAT=2 with a completion
// scoreboard, one at MEM_LAT=1 with IF requesting continuously.
module tb_spcpu_mem_arbiter;

  localparam logic SZ8  = 1'b0;
  localparam logic SZ16 = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: MEM_LAT = 2
  logic        if_req, if_sz, if_gnt, if_done;
  logic [15:0] if_addr, if_rdata;
  logic        ls_req, ls_sz, ls_we, ls_gnt, ls_done;
  logic [15:0] ls_addr, ls_wdata, ls_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_acc_sz;

  // Instance B: MEM_LAT = 1
  logic        b_if_req, b_if_gnt, b_if_done;
  logic [15:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
  logic        b_ls_gnt, b_ls_done, b_mem_we, b_mem_acc_sz;
  logic [15:0] b_mem_rdata;

  spcpu_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_sz(if_sz),
    .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_sz(ls_sz), .ls_we(ls_we),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_acc_sz(mem_acc_sz),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  spcpu_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LAT(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(16'h0100), .if_sz(SZ16),
    .if_gnt(b_if_gnt), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .ls_req(1'b0), .ls_addr(16'h0000), .ls_sz(SZ16), .ls_we(1'b0),
    .ls_wdata(16'h0000), .ls_gnt(b_ls_gnt), .ls_done(b_ls_done), .ls_rdata(b_ls_rdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_acc_sz(b_mem_acc_sz),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_ls;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_if_rdata = 16'h0;
  logic [15:0] m_ls_rdata = 16'h0;
  bit          mon_en = 1'b0;

  // Completion monitor: every done pops one expected entry.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (mon_en && (if_done || ls_done)) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", {30'd0, if_done, ls_done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_who", {if_done, ls_done}, e.is_ls ? 32'd1 : 32'd2);
        chk("done_rdata", e.is_ls ? ls_rdata : if_rdata, e.rdata);
      end
    end
  end

  // One access on instance A, checking grant/done latency and held memory lines.
  task automatic xfer(input bit is_ls, input bit we, input logic sz,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] mdata);
    exp_t        e;
    logic [15:0] rd;
    int          gnt_at = -1;
    int          done_at = -1;
    int          we_cnt = 0;
    int          bad = 0;
    rd = (sz == SZ8) ? {8'h00, mdata[7:0]} : mdata;
    if (is_ls) begin
      if (!we) m_ls_rdata = rd;
      e.rdata = m_ls_rdata;
    end else begin
      m_if_rdata = rd;
      e.rdata = m_if_rdata;
    end
    e.is_ls = is_ls;
    sb.push_back(e);
    mem_rdata = mdata;
    if (is_ls) begin
      ls_req = 1'b1; ls_addr = addr; ls_sz = sz; ls_we = we; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr; if_sz = sz;
    end
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      tick();
      if (is_ls ? ls_gnt : if_gnt) begin
        if (gnt_at < 0) gnt_at = c;
        ls_req = 1'b0;
        if_req = 1'b0;
      end
      if (mem_we) we_cnt++;
      if (gnt_at >= 0) begin
        if (mem_addr !== addr || mem_acc_sz !== sz || (we && mem_wdata !== wdata)) bad++;
      end
      if (is_ls ? ls_done : if_done) done_at = c;
    end
    ls_req = 1'b0;
    if_req = 1'b0;
    chk("gnt_latency", gnt_at, 1);
    chk("done_latency", done_at, 3);
    chk("we_cycles", we_cnt, we ? 2 : 0);
    chk("mem_lines_held", bad, 0);
  endtask

  initial begin
    bit exp_ls [3];
    int ng, nd, last_done, ndone, viol;
    bit pend;
    exp_t e;

    reset = 1'b0;
    if_req = 0; if_addr = 0; if_sz = SZ16;
    ls_req = 0; ls_addr = 0; ls_sz = SZ16; ls_we = 0; ls_wdata = 0;
    mem_rdata = 0; b_if_req = 0; b_mem_rdata = 16'h0042;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {30'd0, if_gnt, ls_gnt}, 0);
    chk("rst_done", {30'd0, if_done, ls_done}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_sz", mem_acc_sz, SZ16);
    reset = 1'b1;
    mon_en = 1'b1;
    tick();

    xfer(1'b0, 1'b0, SZ16, 16'h0010, 16'h0000, 16'hBEEF);
    xfer(1'b1, 1'b0, SZ8,  16'h0021, 16'h0000, 16'hA5C3);
    xfer(1'b1, 1'b1, SZ16, 16'h0020, 16'h1234, 16'h5555);
    xfer(1'b0, 1'b0, SZ8,  16'h0044, 16'h0000, 16'h9A7B);

    // Request withdrawn before the sampling edge: nothing is issued.
    if_addr = 16'h0066;
    if_req = 1'b1;
    #3;
    if_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("drop_no_gnt", {30'd0, if_gnt, ls_gnt}, 0);
      chk("drop_no_we", mem_we, 0);
    end

    // Simultaneous requests held across three grants.
`ifdef SPCPU_MEM_ARB_RR_EN
    exp_ls[0] = 1'b1; exp_ls[1] = 1'b0; exp_ls[2] = 1'b1;
`else
    exp_ls[0] = 1'b1; exp_ls[1] = 1'b1; exp_ls[2] = 1'b1;
`endif
    for (int k = 0; k < 3; k++) begin
      e.is_ls = exp_ls[k];
      e.rdata = 16'h7E11;
      sb.push_back(e);
    end
    mem_rdata = 16'h7E11;
    if_addr = 16'h0070; if_sz = SZ16;
    ls_addr = 16'h0072; ls_sz = SZ16; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    ng = 0; nd = 0;
    for (int c = 0; c < 40 && nd < 3; c++) begin
      tick();
      if (ls_gnt || if_gnt) begin
        if (ng < 3) chk("tie_order_ls", ls_gnt, exp_ls[ng]);
        chk("tie_single_gnt", ls_gnt & if_gnt, 0);
        ng++;
      end
      if (ls_done || if_done) nd++;
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("tie_gnt_count", ng, 3);
    tick();

    // Reset in the second BUSY cycle of an LS byte read.
    mem_rdata = 16'h3C3C;
    ls_addr = 16'h0033; ls_sz = SZ8; ls_we = 1'b0; ls_req = 1'b1;
    tick();
    chk("rst_mid_gnt", ls_gnt, 1);
    ls_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_gnt0", {30'd0, if_gnt, ls_gnt}, 0);
    chk("rst_mid_if_rdata", if_rdata, 0);
    chk("rst_mid_ls_rdata", ls_rdata, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_we", mem_we, 0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    chk("rst_mid_mem_sz", mem_acc_sz, SZ16);
    m_if_rdata = 16'h0;
    m_ls_rdata = 16'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_mid_no_done", ls_done, 0);
    end
    reset = 1'b1;
    tick();
    chk("rst_rel_no_done", ls_done, 0);
    xfer(1'b0, 1'b0, SZ16, 16'h0080, 16'h0000, 16'h1357);
    chk("sb_drained", sb.size(), 0);

    // Instance B: continuous IF requests at MEM_LAT = 1.
    b_if_req = 1'b1;
    last_done = -1; ndone = 0; viol = 0; pend = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (b_if_gnt && b_if_done) viol++;
      if (b_if_done) begin
        if (!pend) viol++;
        pend = 1'b0;
        chk("b_rdata", b_if_rdata, 16'h0042);
        if (last_done >= 0) chk("b_done_gap", c - last_done, 2);
        else chk("b_first_done", c, 2);
        last_done = c;
        ndone++;
      end
      if (b_if_gnt) begin
        if (pend) viol++;
        pend = 1'b1;
      end
      if (b_ls_gnt || b_ls_done) viol++;
    end
    b_if_req = 1'b0;
    chk("b_done_count", ndone, 10);
    chk("b_gnt_done_pairing", viol, 0);
    tick();
    chk("b_mem_addr", b_mem_addr, 16'h0100);
    chk("b_mem_we", b_mem_we, 0);
    chk("b_mem_sz", b_mem_acc_sz, SZ16);
    chk("b_mem_wdata", b_mem_wdata, 0);
    chk("b_ls_rdata", b_ls_rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
